// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: receiver state encoding, debug view and default
// timing constants used by both the receiver and the transmitter.
package ps2_pkg;

  localparam int PS2_FILTER_LEN = 8;
  localparam int PS2_TIMEOUT    = 20000;

  typedef enum logic [1:0] {
    RX_IDLE = 2'd0,
    RX_DPS  = 2'd1,
    RX_LOAD = 2'd2
  } ps2_rx_state_e;

  typedef struct packed {
    ps2_rx_state_e state;
    logic          f_ps2c;
    logic [3:0]    bit_cnt;
  } ps2_rx_dbg_t;

endpackage

// File: rtl/ps2_clk_filter.sv
// Debounces the PS/2 clock line and flags falling edges of the cleaned clock.
// A level is accepted only after FILTER_LEN consecutive identical samples.
module ps2_clk_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic ps2c,
  output logic f_ps2c,
  output logic fall_edge
);

  logic [FILTER_LEN-1:0] filter_q, filter_d;
  logic                  f_ps2c_q, f_ps2c_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      filter_q <= '0;
      f_ps2c_q <= 1'b0;
    end else begin
      filter_q <= filter_d;
      f_ps2c_q <= f_ps2c_d;
    end
  end

  always_comb begin
    filter_d = {ps2c, filter_q[FILTER_LEN-1:1]};
    f_ps2c_d = f_ps2c_q;
    if (filter_q == {FILTER_LEN{1'b1}}) begin
      f_ps2c_d = 1'b1;
    end else if (filter_q == {FILTER_LEN{1'b0}}) begin
      f_ps2c_d = 1'b0;
    end
  end

  assign f_ps2c    = f_ps2c_q;
  assign fall_edge = f_ps2c_q & ~f_ps2c_d;

endmodule

// File: rtl/ps2_rx.sv
// PS/2 receiver: start bit, 8 data bits LSB first, odd parity, stop bit.
// Frames stalled longer than TIMEOUT cycles between clock edges are dropped.
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = PS2_FILTER_LEN,
  parameter int TIMEOUT    = PS2_TIMEOUT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_en,
  input  logic        ps2d,
  input  logic        ps2c,
  output logic        rx_idle,
  output logic        rx_done_tick,
  output logic [7:0]  dout,
  output logic        parity_err,
  output logic        frame_err,
  output logic        timeout_tick,
  output ps2_rx_dbg_t dbg
);

  localparam int            TW       = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT - 1);

  logic          f_ps2c;
  logic          fall_edge;
  ps2_rx_state_e state_q, state_d;
  logic [3:0]    n_q, n_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [9:0]    b_q, b_d;
  logic [7:0]    dout_q, dout_d;
  logic          perr_q, perr_d;
  logic          ferr_q, ferr_d;

  ps2_clk_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_filter (
    .clk      (clk),
    .reset    (reset),
    .ps2c     (ps2c),
    .f_ps2c   (f_ps2c),
    .fall_edge(fall_edge)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RX_IDLE;
      n_q     <= '0;
      tmo_q   <= '0;
      b_q     <= '0;
      dout_q  <= '0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      tmo_q   <= tmo_d;
      b_q     <= b_d;
      dout_q  <= dout_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    n_d          = n_q;
    tmo_d        = tmo_q;
    b_d          = b_q;
    dout_d       = dout_q;
    perr_d       = perr_q;
    ferr_d       = ferr_q;
    rx_done_tick = 1'b0;
    timeout_tick = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (fall_edge && rx_en && !ps2d) begin
          n_d     = 4'd9;
          tmo_d   = TMO_LOAD;
          state_d = RX_DPS;
        end
      end
      RX_DPS: begin
        if (fall_edge) begin
          b_d   = {ps2d, b_q[9:1]};
          tmo_d = TMO_LOAD;
          if (n_q == 4'd0) begin
            // Capture results on the stop edge so they are valid with the tick.
            state_d = RX_LOAD;
            dout_d  = b_d[7:0];
            perr_d  = ~(^b_d[8:0]);
            ferr_d  = ~b_d[9];
          end else begin
            n_d = n_q - 4'd1;
          end
        end else if (tmo_q == '0) begin
          timeout_tick = 1'b1;
          state_d      = RX_IDLE;
        end else begin
          tmo_d = tmo_q - 1'b1;
        end
      end
      RX_LOAD: begin
        rx_done_tick = 1'b1;
        state_d      = RX_IDLE;
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign rx_idle     = (state_q == RX_IDLE);
  assign dout        = dout_q;
  assign parity_err  = perr_q;
  assign frame_err   = ferr_q;
  assign dbg.state   = state_q;
  assign dbg.f_ps2c  = f_ps2c;
  assign dbg.bit_cnt = n_q;

endmodule

// File: tb/tb_ps2_rx.sv
// Bench for ps2_rx: table of frames plus hand-written glitch, timeout and
// mid-frame reset sequences, checked through an expected-result queue.
module tb_ps2_rx;
  import ps2_pkg::*;

  localparam int FLEN = 8;
  localparam int TMO  = 500;

  logic        clk;
  logic        reset;
  logic        rx_en;
  logic        ps2d;
  logic        ps2c;
  logic        rx_idle;
  logic        rx_done_tick;
  logic [7:0]  dout;
  logic        parity_err;
  logic        frame_err;
  logic        timeout_tick;
  ps2_rx_dbg_t dbg;

  ps2_rx #(
    .FILTER_LEN(FLEN),
    .TIMEOUT   (TMO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rx_en       (rx_en),
    .ps2d        (ps2d),
    .ps2c        (ps2c),
    .rx_idle     (rx_idle),
    .rx_done_tick(rx_done_tick),
    .dout        (dout),
    .parity_err  (parity_err),
    .frame_err   (frame_err),
    .timeout_tick(timeout_tick),
    .dbg         (dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       stop;
    logic       en;
    logic       en_drop;
    logic       exp_done;
  } vec_t;

  int         tests;
  int         fails;
  int         done_cnt;
  int         tmo_cnt;
  logic [9:0] exp_q[$];
  logic [9:0] got_q[$];
  logic [9:0] last_out;
  vec_t       vecs[10];

  // monitor: captures every completed frame on the opposite clock edge
  always @(negedge clk) begin
    if (rx_done_tick) begin
      got_q.push_back({dout, parity_err, frame_err});
      done_cnt++;
    end
    if (timeout_tick) tmo_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [10:0] bits, input int nbits, input logic drop);
    for (int i = 0; i < nbits; i++) begin
      ps2d = bits[i];
      wait_clk(25);
      ps2c = 1'b0;
      wait_clk(50);
      if (i == 0 && drop) rx_en = 1'b0;
      ps2c = 1'b1;
      wait_clk(25);
    end
  endtask

  task automatic send_frame(input logic [7:0] data, input logic par, input logic stop,
                            input logic drop);
    send_bits({stop, par, data, 1'b0}, 11, drop);
    ps2d = 1'b1;
  endtask

  // reference: odd parity over data+parity, stop must be 1
  task automatic expect_frame(input logic [7:0] data, input logic par, input logic stop);
    logic [9:0] e;
    e = {data, ($countones({data, par}) % 2 == 0), ~stop};
    exp_q.push_back(e);
    last_out = e;
  endtask

  // scoreboard: compare everything the monitor saw against the expected queue
  task automatic drain(input string name);
    logic [9:0] g;
    logic [9:0] e;
    for (int k = 0; k < 100 && got_q.size() < exp_q.size(); k++) wait_clk(1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (got_q.size() == 0) begin
        check({name, "_missing_done"}, 32'd0, 32'd1);
      end else begin
        g = got_q.pop_front();
        check({name, "_dout"}, 32'(g[9:2]), 32'(e[9:2]));
        check({name, "_parity_err"}, 32'(g[1]), 32'(e[1]));
        check({name, "_frame_err"}, 32'(g[0]), 32'(e[0]));
      end
    end
    check({name, "_extra_done"}, 32'(got_q.size()), 32'd0);
    got_q.delete();
    check({name, "_rx_idle"}, 32'(rx_idle), 32'd1);
    check({name, "_held_out"}, 32'({dout, parity_err, frame_err}), 32'(last_out));
  endtask

  task automatic check_reset_values(input string name);
    check({name, "_dout"}, 32'(dout), 32'h00);
    check({name, "_errs"}, 32'({parity_err, frame_err}), 32'd0);
    check({name, "_ticks"}, 32'({rx_done_tick, timeout_tick}), 32'd0);
    check({name, "_rx_idle"}, 32'(rx_idle), 32'd1);
  endtask

  initial begin
    int tmo_before;
    int done_before;
    int tick_at;
    int idle_bad;

    tests    = 0;
    fails    = 0;
    done_cnt = 0;
    tmo_cnt  = 0;
    last_out = '0;
    reset    = 1'b1;
    rx_en    = 1'b1;
    ps2c     = 1'b1;
    ps2d     = 1'b1;

    vecs[0] = '{8'hFA, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[1] = '{8'hAA, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{8'h55, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[3] = '{8'h12, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{8'h3C, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{8'h81, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    for (int i = 6; i < 10; i++) begin
      vecs[i] = '{8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b1};
    end

    wait_clk(3);
    check_reset_values("reset");
    reset = 1'b0;
    wait_clk(20);
    check_reset_values("post_reset");

    // table-driven frames
    foreach (vecs[i]) begin
      done_before = done_cnt;
      if (vecs[i].exp_done) expect_frame(vecs[i].data, vecs[i].par, vecs[i].stop);
      rx_en = vecs[i].en;
      send_frame(vecs[i].data, vecs[i].par, vecs[i].stop, vecs[i].en_drop);
      rx_en = 1'b1;
      wait_clk(20);
      drain($sformatf("vec%0d", i));
      check($sformatf("vec%0d_done_count", i), 32'(done_cnt - done_before),
            32'(vecs[i].exp_done));
      wait_clk(100);
    end

    // short low glitch on ps2c with ps2d=0 must not start a frame
    tmo_before  = tmo_cnt;
    done_before = done_cnt;
    idle_bad    = 0;
    ps2d        = 1'b0;
    wait_clk(5);
    ps2c = 1'b0;
    wait_clk(3);
    ps2c = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!rx_idle || dbg.state != RX_IDLE) idle_bad++;
    end
    ps2d = 1'b1;
    wait_clk(10);
    check("glitch_idle", 32'(idle_bad), 32'd0);
    check("glitch_ticks", 32'((done_cnt - done_before) + (tmo_cnt - tmo_before)), 32'd0);
    drain("glitch");

    // start + 4 bits, then clock parked high until timeout
    tmo_before  = tmo_cnt;
    done_before = done_cnt;
    tick_at     = -1;
    send_bits({1'b1, 1'b1, 8'h9C, 1'b0}, 4, 1'b0);
    ps2d = 1'b1;
    wait_clk(25);
    ps2c = 1'b0;
    for (int n = 1; n <= FLEN + TMO + 50; n++) begin
      @(posedge clk);
      #1;
      if (n == 50) ps2c = 1'b1;
      @(negedge clk);
      if (timeout_tick) begin
        tick_at = n;
        break;
      end
    end
    check("timeout_latency", 32'(tick_at), 32'(FLEN + TMO));
    wait_clk(5);
    check("timeout_one_pulse", 32'(tmo_cnt - tmo_before), 32'd1);
    check("timeout_no_done", 32'(done_cnt - done_before), 32'd0);
    drain("timeout");
    expect_frame(8'h34, 1'b0, 1'b1);
    send_frame(8'h34, 1'b0, 1'b1, 1'b0);
    wait_clk(20);
    drain("after_timeout");

    // reset pulse after 5 bits of a frame
    wait_clk(50);
    done_before = done_cnt;
    tmo_before  = tmo_cnt;
    send_bits({1'b1, 1'b0, 8'hE7, 1'b0}, 5, 1'b0);
    ps2d = 1'b1;
    reset = 1'b1;
    wait_clk(3);
    check_reset_values("mid_reset");
    reset = 1'b0;
    last_out = '0;
    wait_clk(TMO + 50);
    check_reset_values("after_reset");
    check("reset_no_ticks", 32'((done_cnt - done_before) + (tmo_cnt - tmo_before)), 32'd0);
    drain("reset_partial");
    expect_frame(8'hF4, 1'b0, 1'b1);
    send_frame(8'hF4, 1'b0, 1'b1, 1'b0);
    wait_clk(20);
    drain("after_reset_frame");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
